// File: rtl/counter_pkg.sv
// Shared types and next-state arithmetic for the counter bank channels.
package counter_pkg;

    typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;

    localparam int CNT_MAX_W = 32;

    typedef struct packed {
        logic                 tc;
        logic [CNT_MAX_W-1:0] value;
    } cnt_next_t;

    // Compare happens before the step, so the result never depends on modular overflow.
    function automatic cnt_next_t next_count(
        input logic [CNT_MAX_W-1:0] cur,
        input logic                 dir,
        input logic [CNT_MAX_W-1:0] limit,
        input cnt_mode_e            mode
    );
        cnt_next_t res;
        res.tc    = 1'b0;
        res.value = cur;
        if (dir) begin
            if (cur >= limit) begin
                res.tc    = 1'b1;
                res.value = (mode == CNT_SAT) ? limit : '0;
            end else begin
                res.value = cur + 1'b1;
            end
        end else begin
            if (cur == '0) begin
                res.tc    = 1'b1;
                res.value = (mode == CNT_SAT) ? '0 : limit;
            end else begin
                res.value = cur - 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_channel.sv
// One up/down counter channel with clear, load, wrap/saturate, terminal pulse and sticky overflow.
module counter_channel
    import counter_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int SATURATE = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_dir,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic [WIDTH-1:0] i_limit,
    input  logic             i_ovf_clr,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_ovf
);

    localparam cnt_mode_e MODE = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;

    cnt_next_t nxt;

    always_comb begin
        nxt = next_count(CNT_MAX_W'(o_count), i_dir, CNT_MAX_W'(i_limit), MODE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_count <= '0;
            o_tc    <= 1'b0;
            o_ovf   <= 1'b0;
        end else if (i_clear) begin
            o_count <= '0;
            o_tc    <= 1'b0;
            o_ovf   <= 1'b0;
        end else if (i_load) begin
            o_count <= i_load_val;
            o_tc    <= 1'b0;
            o_ovf   <= o_ovf & ~i_ovf_clr;
        end else if (i_en) begin
            o_count <= nxt.value[WIDTH-1:0];
            o_tc    <= nxt.tc;
            // A terminal event beats a simultaneous flag clear.
            o_ovf   <= nxt.tc | (o_ovf & ~i_ovf_clr);
        end else begin
            o_tc    <= 1'b0;
            o_ovf   <= o_ovf & ~i_ovf_clr;
        end
    end

endmodule

// File: rtl/counter_bank.sv
// Bank of NUM_CH independent counters sharing clock, reset and limit; only slices the flat vectors.
module counter_bank
    import counter_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int NUM_CH   = 4,
    parameter int SATURATE = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_CH-1:0]       i_en,
    input  logic [NUM_CH-1:0]       i_dir,
    input  logic [NUM_CH-1:0]       i_clear,
    input  logic [NUM_CH-1:0]       i_load,
    input  logic [NUM_CH*WIDTH-1:0] i_load_val,
    input  logic [WIDTH-1:0]        i_limit,
    input  logic [NUM_CH-1:0]       i_ovf_clr,
    output logic [NUM_CH*WIDTH-1:0] o_count,
    output logic [NUM_CH-1:0]       o_tc,
    output logic [NUM_CH-1:0]       o_ovf
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        counter_channel #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_ch (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_en       (i_en[c]),
            .i_dir      (i_dir[c]),
            .i_clear    (i_clear[c]),
            .i_load     (i_load[c]),
            .i_load_val (i_load_val[c*WIDTH +: WIDTH]),
            .i_limit    (i_limit),
            .i_ovf_clr  (i_ovf_clr[c]),
            .o_count    (o_count[c*WIDTH +: WIDTH]),
            .o_tc       (o_tc[c]),
            .o_ovf      (o_ovf[c])
        );
    end

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench: a wrap-mode and a saturate-mode bank (WIDTH=4, 4 channels) fed the same stimulus.
module tb_counter_bank;

    localparam int W = 4;
    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   en, dir, clear, load, ovf_clr;
    logic [N*W-1:0] ld_val;
    logic [W-1:0]   limit;
    logic [N*W-1:0] cnt_w, cnt_s;
    logic [N-1:0]   tc_w, tc_s, ovf_w, ovf_s;

    int n_vec = 0;
    int n_err = 0;

    counter_bank #(.WIDTH(W), .NUM_CH(N), .SATURATE(0)) dut_w (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_dir(dir), .i_clear(clear),
        .i_load(load), .i_load_val(ld_val), .i_limit(limit), .i_ovf_clr(ovf_clr),
        .o_count(cnt_w), .o_tc(tc_w), .o_ovf(ovf_w)
    );

    counter_bank #(.WIDTH(W), .NUM_CH(N), .SATURATE(1)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_dir(dir), .i_clear(clear),
        .i_load(load), .i_load_val(ld_val), .i_limit(limit), .i_ovf_clr(ovf_clr),
        .o_count(cnt_s), .o_tc(tc_s), .o_ovf(ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; en = '0; dir = '0; clear = '0; load = '0; ovf_clr = '0; ld_val = '0;
    endtask

    task automatic test_reset();
        idle();
        limit = 4'd5;
        rst = 1;
        step();
        step();
        rst = 0;
        n_vec++;
        if (cnt_w !== 16'h0 || cnt_s !== 16'h0) begin
            n_err++;
            $display("FAIL reset_count got w=%h s=%h exp 0000", cnt_w, cnt_s);
        end
        n_vec++;
        if (tc_w !== 4'h0 || tc_s !== 4'h0) begin
            n_err++;
            $display("FAIL reset_tc got w=%b s=%b exp 0000", tc_w, tc_s);
        end
        n_vec++;
        if (ovf_w !== 4'h0 || ovf_s !== 4'h0) begin
            n_err++;
            $display("FAIL reset_ovf got w=%b s=%b exp 0000", ovf_w, ovf_s);
        end
    endtask

    task automatic test_wrap_up();
        logic [W-1:0] exp_c [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1};
        logic         exp_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        idle();
        limit = 4'd5;
        en[0] = 1; dir[0] = 1;
        for (int i = 0; i < 7; i++) begin
            step();
            n_vec++;
            if (cnt_w[3:0] !== exp_c[i] || tc_w[0] !== exp_t[i]) begin
                n_err++;
                $display("FAIL wrap_up[%0d] got cnt=%0d tc=%b exp cnt=%0d tc=%b",
                         i, cnt_w[3:0], tc_w[0], exp_c[i], exp_t[i]);
            end
        end
        idle();
        n_vec++;
        if (ovf_w[0] !== 1'b1 || cnt_w[15:4] !== 12'h0) begin
            n_err++;
            $display("FAIL wrap_ovf got ovf=%b others=%h exp ovf=1 others=000", ovf_w[0], cnt_w[15:4]);
        end
    endtask

    task automatic test_saturate_down();
        logic [W-1:0] exp_c [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
        logic         exp_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        idle();
        limit = 4'd3;
        load[1] = 1; ld_val[7:4] = 4'd2;
        step();
        idle();
        en[1] = 1; dir[1] = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if (cnt_s[7:4] !== exp_c[i] || tc_s[1] !== exp_t[i]) begin
                n_err++;
                $display("FAIL sat_down[%0d] got cnt=%0d tc=%b exp cnt=%0d tc=%b",
                         i, cnt_s[7:4], tc_s[1], exp_c[i], exp_t[i]);
            end
        end
        n_vec++;
        if (ovf_s[1] !== 1'b1) begin
            n_err++;
            $display("FAIL sat_down_ovf got %b exp 1", ovf_s[1]);
        end
        // Saturate at the top: count pinned at limit, tc high every enabled cycle.
        dir[1] = 1;
        for (int i = 0; i < 5; i++) step();
        n_vec++;
        if (cnt_s[7:4] !== 4'd3 || tc_s[1] !== 1'b1) begin
            n_err++;
            $display("FAIL sat_up_hold got cnt=%0d tc=%b exp cnt=3 tc=1", cnt_s[7:4], tc_s[1]);
        end
        idle();
        step();
        n_vec++;
        if (tc_s[1] !== 1'b0 || cnt_s[7:4] !== 4'd3) begin
            n_err++;
            $display("FAIL sat_idle got cnt=%0d tc=%b exp cnt=3 tc=0", cnt_s[7:4], tc_s[1]);
        end
    endtask

    task automatic test_priority();
        idle();
        limit = 4'd5;
        load[2] = 1; ld_val[11:8] = 4'd7;
        step();
        idle();
        en[2] = 1; dir[2] = 1;
        step();
        n_vec++;
        if (cnt_w[11:8] !== 4'd0 || tc_w[2] !== 1'b1 || ovf_w[2] !== 1'b1) begin
            n_err++;
            $display("FAIL prio_wrap got cnt=%0d tc=%b ovf=%b exp 0 1 1", cnt_w[11:8], tc_w[2], ovf_w[2]);
        end
        idle();
        load[2] = 1; ld_val[11:8] = 4'd7;
        step();
        n_vec++;
        if (cnt_w[11:8] !== 4'd7 || tc_w[2] !== 1'b0 || ovf_w[2] !== 1'b1) begin
            n_err++;
            $display("FAIL prio_load got cnt=%0d tc=%b ovf=%b exp 7 0 1", cnt_w[11:8], tc_w[2], ovf_w[2]);
        end
        clear[2] = 1; load[2] = 1; en[2] = 1; dir[2] = 1; ld_val[11:8] = 4'd9;
        step();
        n_vec++;
        if (cnt_w[11:8] !== 4'd0 || ovf_w[2] !== 1'b0) begin
            n_err++;
            $display("FAIL prio_clear got cnt=%0d ovf=%b exp 0 0", cnt_w[11:8], ovf_w[2]);
        end
        clear[2] = 0;
        step();
        n_vec++;
        if (cnt_w[11:8] !== 4'd9 || tc_w[2] !== 1'b0) begin
            n_err++;
            $display("FAIL prio_load_en got cnt=%0d tc=%b exp 9 0", cnt_w[11:8], tc_w[2]);
        end
    endtask

    task automatic test_out_of_range();
        idle();
        limit = 4'd5;
        load[3] = 1; ld_val[15:12] = 4'd12;
        step();
        idle();
        en[3] = 1; dir[3] = 1;
        step();
        n_vec++;
        if (cnt_w[15:12] !== 4'd0 || tc_w[3] !== 1'b1) begin
            n_err++;
            $display("FAIL oor_up got cnt=%0d tc=%b exp 0 1", cnt_w[15:12], tc_w[3]);
        end
        idle();
        load[3] = 1; ld_val[15:12] = 4'd12;
        step();
        idle();
        en[3] = 1; dir[3] = 0;
        step();
        n_vec++;
        if (cnt_w[15:12] !== 4'd11 || tc_w[3] !== 1'b0) begin
            n_err++;
            $display("FAIL oor_down got cnt=%0d tc=%b exp 11 0", cnt_w[15:12], tc_w[3]);
        end
    endtask

    task automatic test_ovf_clr();
        idle();
        limit = 4'd5;
        clear[0] = 1;
        step();
        idle();
        load[0] = 1; ld_val[3:0] = 4'd5;
        step();
        idle();
        en[0] = 1; dir[0] = 1; ovf_clr[0] = 1;
        step();
        n_vec++;
        if (cnt_w[3:0] !== 4'd0 || tc_w[0] !== 1'b1 || ovf_w[0] !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set_wins got cnt=%0d tc=%b ovf=%b exp 0 1 1", cnt_w[3:0], tc_w[0], ovf_w[0]);
        end
        idle();
        ovf_clr[0] = 1;
        step();
        n_vec++;
        if (ovf_w[0] !== 1'b0 || tc_w[0] !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clr_alone got ovf=%b tc=%b exp 0 0", ovf_w[0], tc_w[0]);
        end
    endtask

    task automatic test_limit_zero();
        idle();
        limit = 4'd0;
        en[0] = 1; dir[0] = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++;
            if (cnt_w[3:0] !== 4'd0 || tc_w[0] !== 1'b1 || cnt_s[3:0] !== 4'd0 || tc_s[0] !== 1'b1) begin
                n_err++;
                $display("FAIL limit_zero[%0d] got w=%0d/%b s=%0d/%b exp 0/1", i,
                         cnt_w[3:0], tc_w[0], cnt_s[3:0], tc_s[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        idle();
        limit = 4'd15;
        clear = '1;
        step();
        idle();
        en = '1; dir = '1;
        for (int i = 0; i < 3; i++) step();
        rst = 1;
        step();
        n_vec++;
        if (cnt_w !== 16'h0 || tc_w !== 4'h0 || ovf_w !== 4'h0 || cnt_s !== 16'h0) begin
            n_err++;
            $display("FAIL reset_mid got cnt=%h tc=%b ovf=%b exp 0000 0000 0000", cnt_w, tc_w, ovf_w);
        end
        rst = 0;
        step();
        n_vec++;
        if (cnt_w !== 16'h1111 || tc_w !== 4'h0) begin
            n_err++;
            $display("FAIL reset_resume got cnt=%h tc=%b exp 1111 0000", cnt_w, tc_w);
        end
        en = 4'b0101;
        step();
        n_vec++;
        if (cnt_w !== 16'h1212 || cnt_s !== 16'h1212) begin
            n_err++;
            $display("FAIL independent got w=%h s=%h exp 1212", cnt_w, cnt_s);
        end
    endtask

    initial begin
        idle();
        limit = '0;
        rst = 1;
        test_reset();
        test_wrap_up();
        test_saturate_down();
        test_priority();
        test_out_of_range();
        test_ovf_clr();
        test_limit_zero();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
